// File: rtl/comm_hybrid_link.sv
// rtl/comm_hybrid_link.sv - hybrid UART/SPI loopback link engine
// Sends one word per transaction over UART frames or SPI mode 0, deserialises the return line and reports match.
module comm_hybrid_link #(
   parameter int DATA_W       = 32,
   parameter int UART_BITS    = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int SPI_HALF     = 2,
   parameter int PARITY_EN    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start_valid,
   output logic              o_start_ready,
   input  logic              i_select,
   input  logic [DATA_W-1:0] i_data_in,
   output logic              o_uart_tx,
   input  logic              i_uart_rx,
   output logic              o_spi_cs_n,
   output logic              o_spi_sclk,
   output logic              o_spi_mosi,
   input  logic              i_spi_miso,
   output logic              o_done,
   output logic              o_data_match,
   output logic              o_parity_err,
   output logic [DATA_W-1:0] o_dataout
);

   localparam int NF         = DATA_W / UART_BITS;
   localparam int FRAME_BITS = UART_BITS + 2 + PARITY_EN;
   localparam int CW         = $clog2(CLKS_PER_BIT);
   localparam int BW         = $clog2(FRAME_BITS);
   localparam int FW         = (NF > 1) ? $clog2(NF) : 1;
   localparam int HW         = (SPI_HALF > 1) ? $clog2(SPI_HALF) : 1;
   localparam int SW         = $clog2(DATA_W + 1);

   localparam logic [CW-1:0] CLK_LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CLK_MID       = CW'(CLKS_PER_BIT / 2);
   localparam logic [BW-1:0] BIT_LAST_DATA = BW'(UART_BITS);
   localparam logic [BW-1:0] BIT_STOP      = BW'(FRAME_BITS - 1);
   localparam logic [FW-1:0] FRAME_LAST    = FW'(NF - 1);
   localparam logic [HW-1:0] HALF_LAST     = HW'(SPI_HALF - 1);
   localparam logic [SW-1:0] SPI_BITS      = SW'(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_UART_XFER,
      S_SPI_XFER,
      S_CHECK
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_clk_cnt;
   logic [BW-1:0]     r_bit_cnt;
   logic [FW-1:0]     r_frame_cnt;
   logic [HW-1:0]     r_half_cnt;
   logic [SW-1:0]     r_spi_bits;
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_rx_shift;
   logic [DATA_W-1:0] r_sent_word;
   logic              r_tx_par;
   logic              r_rx_par;
   logic              r_parity_err_int;
   logic              r_framing_ok;
   logic              w_accept;

   assign w_accept = i_start_valid & o_start_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= S_IDLE;
         r_clk_cnt        <= '0;
         r_bit_cnt        <= '0;
         r_frame_cnt      <= '0;
         r_half_cnt       <= '0;
         r_spi_bits       <= '0;
         r_tx_shift       <= '0;
         r_rx_shift       <= '0;
         r_sent_word      <= '0;
         r_tx_par         <= 1'b0;
         r_rx_par         <= 1'b0;
         r_parity_err_int <= 1'b0;
         r_framing_ok     <= 1'b1;
         o_start_ready    <= 1'b1;
         o_uart_tx        <= 1'b1;
         o_spi_cs_n       <= 1'b1;
         o_spi_sclk       <= 1'b0;
         o_spi_mosi       <= 1'b0;
         o_done           <= 1'b0;
         o_data_match     <= 1'b0;
         o_parity_err     <= 1'b0;
         o_dataout        <= '0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx_shift       <= i_data_in;
                  r_sent_word      <= i_data_in;
                  r_rx_shift       <= '0;
                  r_clk_cnt        <= '0;
                  r_bit_cnt        <= '0;
                  r_frame_cnt      <= '0;
                  r_half_cnt       <= '0;
                  r_spi_bits       <= '0;
                  r_rx_par         <= 1'b0;
                  r_parity_err_int <= 1'b0;
                  r_framing_ok     <= 1'b1;
                  o_start_ready    <= 1'b0;
                  if (i_select) begin
                     r_state    <= S_SPI_XFER;
                     o_spi_cs_n <= 1'b0;
                     o_spi_sclk <= 1'b0;
                     o_spi_mosi <= i_data_in[DATA_W-1];
                  end else begin
                     r_state   <= S_UART_XFER;
                     o_uart_tx <= 1'b0;
                     r_tx_par  <= ^i_data_in[UART_BITS-1:0];
                  end
               end
            end

            S_UART_XFER: begin
               // Receiver shares the transmit bit counter and samples mid-bit.
               if (r_clk_cnt == CLK_MID) begin
                  if (r_bit_cnt == '0) begin
                     r_rx_par <= 1'b0;
                     if (i_uart_rx != 1'b0) r_framing_ok <= 1'b0;
                  end else if (r_bit_cnt <= BIT_LAST_DATA) begin
                     r_rx_shift <= {i_uart_rx, r_rx_shift[DATA_W-1:1]};
                     r_rx_par   <= r_rx_par ^ i_uart_rx;
                  end else if (r_bit_cnt == BIT_STOP) begin
                     if (i_uart_rx != 1'b1) r_framing_ok <= 1'b0;
                  end else begin
                     if (i_uart_rx != r_rx_par) r_parity_err_int <= 1'b1;
                  end
               end

               if (r_clk_cnt == CLK_LAST) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == BIT_STOP) begin
                     r_bit_cnt <= '0;
                     if (r_frame_cnt == FRAME_LAST) begin
                        r_state   <= S_CHECK;
                        o_uart_tx <= 1'b1;
                     end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        o_uart_tx   <= 1'b0;
                        r_tx_par    <= ^r_tx_shift[UART_BITS-1:0];
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt < BIT_LAST_DATA) begin
                        o_uart_tx  <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
                     end else if ((PARITY_EN != 0) && (r_bit_cnt == BIT_LAST_DATA)) begin
                        o_uart_tx <= r_tx_par;
                     end else begin
                        o_uart_tx <= 1'b1;
                     end
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

            S_SPI_XFER: begin
               if (r_half_cnt == HALF_LAST) begin
                  r_half_cnt <= '0;
                  if (!o_spi_sclk) begin
                     o_spi_sclk <= 1'b1;
                     r_rx_shift <= {r_rx_shift[DATA_W-2:0], i_spi_miso};
                     r_spi_bits <= r_spi_bits + 1'b1;
                  end else begin
                     o_spi_sclk <= 1'b0;
                     if (r_spi_bits == SPI_BITS) begin
                        o_spi_cs_n <= 1'b1;
                        o_spi_mosi <= 1'b0;
                        r_state    <= S_CHECK;
                     end else begin
                        o_spi_mosi <= r_tx_shift[DATA_W-2];
                        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                     end
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + 1'b1;
               end
            end

            S_CHECK: begin
               o_dataout     <= r_rx_shift;
               o_data_match  <= (r_rx_shift == r_sent_word) & ~r_parity_err_int & r_framing_ok;
               o_parity_err  <= r_parity_err_int;
               o_done        <= 1'b1;
               o_start_ready <= 1'b1;
               r_state       <= S_IDLE;
            end

            default: begin
               r_state       <= S_IDLE;
               o_start_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comm_hybrid_link.sv
// tb/tb_comm_hybrid_link.sv - self-checking bench for comm_hybrid_link
// Waveform model derived from frame/bit arithmetic, checked every cycle of each transaction.
module tb_comm_hybrid_link;

   localparam int LAT_U = 177;
   localparam int LAT_S = 129;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic        sel;
   logic [31:0] din;
   logic        uart_tx;
   logic        uart_rx;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        done;
   logic        data_match;
   logic        parity_err;
   logic [31:0] dataout;

   logic rx_inv    = 1'b0;
   logic spi_stuck = 1'b0;

   always #5 clk = ~clk;

   assign uart_rx  = uart_tx ^ rx_inv;
   assign spi_miso = spi_stuck ? 1'b0 : spi_mosi;

   comm_hybrid_link dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start_valid (start_valid),
      .o_start_ready (start_ready),
      .i_select      (sel),
      .i_data_in     (din),
      .o_uart_tx     (uart_tx),
      .i_uart_rx     (uart_rx),
      .o_spi_cs_n    (spi_cs_n),
      .o_spi_sclk    (spi_sclk),
      .o_spi_mosi    (spi_mosi),
      .i_spi_miso    (spi_miso),
      .o_done        (done),
      .o_data_match  (data_match),
      .o_parity_err  (parity_err),
      .o_dataout     (dataout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bit idx of the whole UART stream: 11 bits per frame (start, 8 data, even parity, stop).
   function automatic logic uart_bit(input logic [31:0] w, input int idx);
      logic [7:0] chunk;
      int         b;
      chunk = 8'(w >> (8 * (idx / 11)));
      b     = idx % 11;
      if (b == 0)       return 1'b0;
      else if (b == 9)  return ^chunk;
      else if (b == 10) return 1'b1;
      else              return chunk[b-1];
   endfunction

   logic        active   = 1'b0;
   logic        chk_idle = 1'b0;
   int          k;
   logic        m_spi;
   logic [31:0] m_word;
   int          m_kind;
   int          m_lat;
   logic [31:0] m_dout;
   logic        m_match;
   logic        m_perr;
   int          done_k;
   int          rise_cnt;
   logic        prev_sclk;
   logic [7:0]  cap_byte;
   logic        cap_par;

   always @(negedge clk) begin
      if (active) begin
         if (!m_spi) begin
            rx_inv = (m_kind == 1) && ((k / 4) == 11 * 1 + 9);
            chk("uart_tx", uart_tx, (k < 176) ? uart_bit(m_word, k / 4) : 1'b1);
            chk("uart_cs_n", spi_cs_n, 1);
            chk("uart_sclk", spi_sclk, 0);
            if (k >= 4 && k < 36 && (k % 4) == 2) cap_byte[k/4-1] = uart_tx;
            if (k == 38) cap_par = uart_tx;
         end else begin
            chk("spi_cs_n", spi_cs_n, (k < 128) ? 0 : 1);
            chk("spi_sclk", spi_sclk, (k < 128) ? ((k / 2) % 2) : 0);
            if (k < 128) chk("spi_mosi", spi_mosi, m_word[31 - k/4]);
            chk("spi_uart_tx", uart_tx, 1);
            if (spi_sclk && !prev_sclk && !spi_cs_n) rise_cnt++;
            prev_sclk = spi_sclk;
         end
         chk("done", done, (k == m_lat) ? 1 : 0);
         chk("start_ready", start_ready, (k >= m_lat) ? 1 : 0);
         if (done && done_k < 0) done_k = k;
         if (k == m_lat) begin
            chk("dataout", dataout, m_dout);
            chk("data_match", data_match, m_match);
            chk("parity_err", parity_err, m_perr);
            active = 1'b0;
            rx_inv = 1'b0;
         end
         k++;
      end else if (chk_idle && !rst) begin
         chk("idle_done", done, 0);
      end
   end

   // kind: 0 = clean loopback, 1 = frame-1 parity bit inverted, 2 = miso stuck low
   task automatic start_txn(input logic spi, input logic [31:0] w, input int kind);
      @(negedge clk);
      chk("ready_before", start_ready, 1);
      m_spi     = spi;
      m_word    = w;
      m_kind    = kind;
      m_lat     = spi ? LAT_S : LAT_U;
      m_dout    = (kind == 2) ? 32'h0 : w;
      m_perr    = (kind == 1);
      m_match   = (m_dout == w) && !m_perr;
      spi_stuck = (kind == 2);
      done_k    = -1;
      rise_cnt  = 0;
      prev_sclk = 1'b0;
      cap_byte  = 8'h00;
      cap_par   = 1'b0;
      sel       = spi;
      din       = w;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      sel = ~spi;
      din = ~w;
      k = 0;
      active = 1'b1;
   endtask

   task automatic wait_txn();
      for (int i = 0; i < 400 && active; i++) @(negedge clk);
      if (active) begin
         chk("timeout", 1, 0);
         active = 1'b0;
      end
      spi_stuck = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start_valid = 1'b0;
      sel = 1'b0;
      din = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_cs_n", spi_cs_n, 1);
      chk("rst_sclk", spi_sclk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", start_ready, 1);
      chk("rst_dataout", dataout, 0);
      chk("rst_match", data_match, 0);
      chk("rst_perr", parity_err, 0);
      chk_idle = 1'b1;

      start_txn(1'b0, 32'hDEADBEEF, 0);
      wait_txn();
      chk("uart_latency", done_k, 177);
      chk("frame0_data", cap_byte, 8'hEF);
      chk("frame0_parity", cap_par, 1);

      start_txn(1'b1, 32'h12345678, 0);
      wait_txn();
      chk("spi_latency", done_k, 129);
      chk("spi_rises", rise_cnt, 32);
      chk("spi_dout_lit", dataout, 32'h12345678);

      start_txn(1'b0, 32'hA5A5A5A5, 1);
      wait_txn();
      chk("perr_lit", parity_err, 1);
      chk("perr_match_lit", data_match, 0);

      start_txn(1'b1, 32'hFFFFFFFF, 2);
      wait_txn();
      chk("stuck_dout_lit", dataout, 32'h00000000);

      start_txn(1'b0, 32'h0F1E2D3C, 0);
      for (int i = 0; i < 100 && active && k < 60; i++) @(negedge clk);
      active = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_uart_tx", uart_tx, 1);
      chk("abort_ready", start_ready, 1);
      chk("abort_done", done, 0);
      repeat (200) @(negedge clk);

      start_txn(1'b1, 32'h0000FFFF, 0);
      wait_txn();
      chk("post_abort_latency", done_k, 129);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/comm_hybrid_link.md
Name: comm_hybrid_link

Overview:
Parametrised hybrid UART/SPI loopback link engine. It accepts one DATA_W word per transaction and serialises it over either a UART framed line or an SPI master interface, chosen per transaction. It simultaneously deserialises the returning line, then reports a word match/mismatch with the received data. It sits between the system data source and the external serial pins, replacing the fixed 32-bit, UART-only match check with a configurable, handshaked, timed engine.

Parameters:
DATA_W, 32, transaction word width; must be a multiple of UART_BITS.
UART_BITS, 8, data bits per UART frame.
CLKS_PER_BIT, 4, clk cycles per UART bit; even, >=2.
SPI_HALF, 2, clk cycles per SPI sclk half-period; >=1.
PARITY_EN, 1, 1 = even parity bit in each UART frame, 0 = no parity bit.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  request a transaction; data_in/select sampled when start_valid & start_ready
start_ready  output  1  high only in IDLE
select  input  1  0 = UART mode, 1 = SPI mode
data_in  input  DATA_W  word to transmit
uart_tx  output  1  UART serial out, idle high
uart_rx  input  1  UART serial in
spi_cs_n  output  1  SPI chip select, active low
spi_sclk  output  1  SPI clock, mode 0 (idle low)
spi_mosi  output  1  SPI data out, MSB first
spi_miso  input  1  SPI data in
done  output  1  one-cycle pulse at end of transaction
data_match  output  1  valid with done: received word == sent word and no parity error
parity_err  output  1  valid with done: any UART frame parity mismatch (always 0 in SPI mode)
dataout  output  DATA_W  received word; held until next done

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; uart_tx=1, spi_cs_n=1, spi_sclk=0, spi_mosi=0, done=0, data_match=0, parity_err=0, dataout=0, start_ready=1. Reset mid-transaction aborts immediately with no done pulse.
- FSM states: IDLE, UART_XFER, SPI_XFER, CHECK.
- IDLE: on start_valid & start_ready, latch data_in into tx_shift and a copy into sent_word, latch select. Next state UART_XFER if select=0, else SPI_XFER. start_ready drops the next cycle.
- UART_XFER: NF = DATA_W/UART_BITS frames, sent back-to-back, least significant chunk first.
  - Frame = start(0), UART_BITS data LSB first, parity (if PARITY_EN, even: XOR of data bits), stop(1).
  - Each bit is driven for exactly CLKS_PER_BIT cycles.
  - The receiver runs lock-step on the same bit counter and samples uart_rx at cycle CLKS_PER_BIT/2 of each bit.
  - Received data bits are assembled into rx_shift in matching position. A sampled parity bit differing from the recomputed parity sets the sticky parity_err_int.
  - A sampled start != 0 or stop != 1 counts as a mismatch and forces data_match=0.
  - After the last stop bit: go to CHECK; uart_tx returns to 1.
- SPI_XFER:
  - spi_cs_n=0 throughout.
  - spi_mosi is updated with the next bit (MSB first) while sclk is low.
  - sclk toggles every SPI_HALF cycles.
  - spi_miso is sampled on each sclk rising transition, shifted into rx_shift LSB.
  - After DATA_W rising edges and the following falling edge: spi_cs_n=1, go to CHECK.
- CHECK (1 cycle):
  - dataout <= rx_shift.
  - data_match <= (rx_shift == sent_word) & ~parity_err_int & framing_ok.
  - parity_err <= parity_err_int.
  - done <= 1 for exactly this one cycle; return to IDLE.
- Latency, acceptance edge to done:
  - UART: 1 + NF*(UART_BITS+1+PARITY_EN+1)*CLKS_PER_BIT cycles (defaults: 1 + 4*11*4 = 177).
  - SPI: 1 + DATA_W*2*SPI_HALF cycles (defaults: 129).
- start_valid outside IDLE is ignored; there is no queuing.
- select changes are ignored except at acceptance.
- data_match, parity_err and dataout hold their values until the next CHECK.
- All counters wrap exactly at their terminal value; there are no off-by-one extra bit periods between frames.

Test Plan:
- Reset held 3 cycles, then released -> uart_tx=1, spi_cs_n=1, spi_sclk=0, done=0, start_ready=1, dataout=0.
- UART loopback (uart_rx tied to uart_tx), select=0, data_in=32'hDEADBEEF -> done pulses 177 cycles after accept; data_match=1, parity_err=0, dataout=32'hDEADBEEF; first frame data bits carry 8'hEF LSB first.
- SPI loopback (spi_miso tied to spi_mosi), select=1, data_in=32'h12345678 -> done after 129 cycles; data_match=1, dataout=32'h12345678; exactly 32 sclk rising edges with cs_n low.
- UART with the parity bit of frame 2 inverted on uart_rx, data_in=32'hA5A5A5A5 -> parity_err=1, data_match=0, dataout=32'hA5A5A5A5.
- SPI with spi_miso stuck at 0, data_in=32'hFFFFFFFF -> data_match=0, dataout=32'h00000000, parity_err=0.
- Assert rst mid-UART transfer (cycle 60), then start a new SPI transaction with 32'h0000FFFF -> no done from the aborted transfer; uart_tx=1 after reset; new transaction completes with data_match=1.
